operand_bypass_unit: RTL and testbench
======================================

Name: operand_bypass_unit

Overview:
- Parametrised successor to the single-operand 3:1 ALU forwarding mux.
- Tracks in-flight register writes in a DEPTH-entry shift pipe and selects the bypass source for NUM_SRC operands. Covers register 0, youngest-wins priority and stall cases the old mux did not.
- Detects load-use hazards and raises a stall; registers the chosen operands into the ID/EX boundary.
- Sits between decode/register-file read and the EX stage of the core pipeline.

Parameters:
- DATA_W, 32, operand/result width
- REG_ADDR_W, 5, register specifier width
- DEPTH, 3, number of tracked downstream stages (0=EX, 1=MEM, 2=WB)
- NUM_SRC, 2, operand read ports
- LOAD_READY_STAGE, 2, first stage index at which load data is valid on stage_data

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- advance  input  1  pipeline enable; low = whole pipe holds
- flush  input  1  squash all tracked entries and the output operand
- issue_valid  input  1  decode holds a valid instruction
- issue_we  input  1  issuing instruction writes a register
- issue_is_load  input  1  issuing instruction is a load
- issue_rd  input  REG_ADDR_W  issuing destination register
- src_addr  input  NUM_SRC*REG_ADDR_W  source specifiers, port s at [s*REG_ADDR_W +: REG_ADDR_W]
- rf_data  input  NUM_SRC*DATA_W  register-file read data per port
- stage_data  input  DEPTH*DATA_W  result currently held by stage k
- stall  output  1  combinational load-use stall to fetch/decode
- op_valid  output  1  registered: operand bundle valid for EX
- operand  output  NUM_SRC*DATA_W  registered selected operands
- fwd_sel  output  NUM_SRC*2 (clog2(DEPTH+1) in general)  registered source per port: 0 = RF, k+1 = stage k

Behaviour:
- Entry k: valid, rd, is_load. An entry is tracked only when issue_valid & issue_we & issue_rd != 0.
- Match for port s:
  - Lowest k with ent[k].valid and ent[k].rd == src[s] and src[s] != 0. Youngest wins.
  - No match: select rf_data.
  - src == 0: always rf_data, fwd_sel = 0, never a hazard.
- Hazard for port s: the match is a load and k < LOAD_READY_STAGE.
- stall = issue_valid & OR of hazards over all ports. Combinational, same cycle.
- Clock edge, priority order:
  - rst: all entries invalid, op_valid=0, operand=0, fwd_sel=0.
  - flush: same clearing as rst.
  - !advance: hold entries and outputs.
  - advance & stall: bubble into ent[0], shift ent[k] <= ent[k-1], op_valid=0, operand/fwd_sel hold.
  - advance & !stall: ent[0] <= issue, shift; op_valid <= issue_valid; operand/fwd_sel <= selection.
- Latency: one cycle from issue to operand.
- Stall resolution: a load in EX stalls 2 cycles with the default parameters. A load in MEM stalls 1 cycle.
- rst or flush asserted while stall is high: stall drops the next cycle because the entries are cleared.
- Simultaneous flush & advance: flush wins, and no new entry is captured.

Decomposition:
- Package bypass_pkg:
  - fwd_sel encoding constants (FWD_RF=0, FWD_STAGE_BASE=1)
  - entry record (valid, rd, is_load)
  - clog2 helper
- Sub-module bypass_tracker: DEPTH shift pipe with advance/bubble/flush/reset.
- Match, hazard and select logic plus the output registers stay in the top level, generated per port.

Test Plan:
- Back-to-back ALU dependency:
  - Stimulus: r3 written, next instruction reads r3; stage_data[0]=0x1111_0000, rf_data=0xDEAD.
  - Required: stall=0, operand=0x1111_0000, fwd_sel=1.
- Load-use:
  - Stimulus: lw r5, then immediate read of r5.
  - Required: stall high 2 cycles with op_valid=0. Then operand = stage_data[2], fwd_sel=3.
- Register 0:
  - Stimulus: write r0, then read r0.
  - Required: no stall, operand=rf_data, fwd_sel=0.
- Youngest wins:
  - Stimulus: r7 written in ent[0] and ent[2]; stage_data[0]=0xA, stage_data[2]=0xB.
  - Required: operand=0xA, fwd_sel=1. Repeat on port 1 simultaneously.
- advance=0 for 3 cycles mid-stream:
  - Required: entries and operand frozen. On resume, selection resumes with unchanged fwd_sel.
- rst/flush during a load-use stall:
  - Required: next cycle stall=0, op_valid=0, all fwd_sel=0. A following read of the same register takes rf_data.

Source files
------------

// File: rtl/bypass_pkg.sv
// Shared types and constants for the operand bypass unit: the fwd_sel
// encoding, the tracked-write entry record and a width helper.
package bypass_pkg;

   // fwd_sel encoding: 0 selects the register file, k+1 selects stage k.
   localparam int FWD_RF         = 0;
   localparam int FWD_STAGE_BASE = 1;

   // Widest register specifier an entry can hold. Narrower specifiers are
   // zero-extended into it, so the unused upper bits are constant zero.
   localparam int RD_W_MAX = 8;

   // One in-flight register write.
   typedef struct packed {
      logic                valid;
      logic [RD_W_MAX-1:0] rd;
      logic                is_load;
   } entry_t;

   // Ceiling log2 for parameter-derived widths; never narrower than 1 bit.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         bits++;
      end
      return (bits == 0) ? 1 : bits;
   endfunction

endpackage

// File: rtl/bypass_tracker.sv
// Shift pipe of in-flight register writes. ent[0] mirrors EX, ent[1] MEM,
// and so on. A stall pushes a bubble in behind the stalled instruction.
module bypass_tracker
   import bypass_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 advance,
   input  logic                 flush,
   input  logic                 stall,
   input  entry_t               new_ent,
   output entry_t [DEPTH-1:0]   ent
);

   // Clear on reset/flush, otherwise shift one stage whenever the pipe advances.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and active-high, so it is just the
      // highest-priority branch inside the clocked block, not in the
      // sensitivity list.
      if (rst || flush) begin
         ent <= '0;
      end else if (advance) begin
         // NOTE: non-blocking assignments let every stage sample its
         // predecessor's old value, so the shift order in the loop does not
         // matter.
         ent[0] <= stall ? '0 : new_ent;
         for (int k = 1; k < DEPTH; k++) begin
            ent[k] <= ent[k-1];
         end
      end
   end

endmodule

// File: rtl/operand_bypass_unit.sv
// Operand bypass unit: per read port, picks the youngest in-flight producer
// of the source register (or the register file), raises a load-use stall
// when that producer's data is not ready yet, and registers the chosen
// operands into the ID/EX boundary.
module operand_bypass_unit
   import bypass_pkg::*;
#(
   parameter int DATA_W           = 32,
   parameter int REG_ADDR_W       = 5,
   parameter int DEPTH            = 3,
   parameter int NUM_SRC          = 2,
   parameter int LOAD_READY_STAGE = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   advance,
   input  logic                                   flush,
   input  logic                                   issue_valid,
   input  logic                                   issue_we,
   input  logic                                   issue_is_load,
   input  logic [REG_ADDR_W-1:0]                  issue_rd,
   input  logic [NUM_SRC*REG_ADDR_W-1:0]          src_addr,
   input  logic [NUM_SRC*DATA_W-1:0]              rf_data,
   input  logic [DEPTH*DATA_W-1:0]                stage_data,
   output logic                                   stall,
   output logic                                   op_valid,
   output logic [NUM_SRC*DATA_W-1:0]              operand,
   output logic [NUM_SRC*clog2(DEPTH+1)-1:0]      fwd_sel
);

   localparam int SEL_W = clog2(DEPTH + 1);

   entry_t                     new_ent;
   entry_t [DEPTH-1:0]         ent;
   wire  [NUM_SRC-1:0]         hazard;
   wire  [NUM_SRC*DATA_W-1:0]  op_next;
   wire  [NUM_SRC*SEL_W-1:0]   sel_next;

   // Build the entry for the issuing instruction; r0 writes are never tracked.
   always_comb begin
      new_ent         = '0;
      new_ent.valid   = issue_valid && issue_we && (issue_rd != '0);
      new_ent.rd      = RD_W_MAX'(issue_rd);
      new_ent.is_load = issue_is_load;
   end

   bypass_tracker #(
      .DEPTH (DEPTH)
   ) u_tracker (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .flush   (flush),
      .stall   (stall),
      .new_ent (new_ent),
      .ent     (ent)
   );

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_port
      logic [REG_ADDR_W-1:0] src;
      logic [SEL_W-1:0]      hit_sel;
      logic [DATA_W-1:0]     hit_data;
      logic                  hit_haz;

      assign src = src_addr[s*REG_ADDR_W +: REG_ADDR_W];

      // Scan oldest to youngest so the lowest matching stage overwrites the rest.
      always_comb begin
         hit_sel  = SEL_W'(FWD_RF);
         hit_data = rf_data[s*DATA_W +: DATA_W];
         hit_haz  = 1'b0;
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if ((src != '0) && ent[k].valid && (ent[k].rd == RD_W_MAX'(src))) begin
               hit_sel  = SEL_W'(k + FWD_STAGE_BASE);
               hit_data = stage_data[k*DATA_W +: DATA_W];
               hit_haz  = ent[k].is_load && (k < LOAD_READY_STAGE);
            end
         end
      end

      assign hazard[s]                      = hit_haz;
      assign op_next[s*DATA_W +: DATA_W]    = hit_data;
      assign sel_next[s*SEL_W +: SEL_W]     = hit_sel;
   end

   // A hazard only matters when decode actually holds an instruction.
   assign stall = issue_valid && (|hazard);

   // ID/EX boundary: bubble on stall, hold on !advance, capture otherwise.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         op_valid <= 1'b0;
         operand  <= '0;
         fwd_sel  <= '0;
      end else if (advance) begin
         if (stall) begin
            op_valid <= 1'b0;
         end else begin
            op_valid <= issue_valid;
            operand  <= op_next;
            fwd_sel  <= sel_next;
         end
      end
   end

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed bench for operand_bypass_unit: a vector table walked cycle by
// cycle, followed by a hand-written reset-during-stall sequence.
module tb_operand_bypass_unit;

   localparam logic [31:0] RF0 = 32'h0000_DEAD;
   localparam logic [31:0] RF1 = 32'h0000_BEEF;
   localparam logic [31:0] SA  = 32'h1111_0000;
   localparam logic [31:0] SB  = 32'h2222_0000;
   localparam logic [31:0] SC  = 32'h3333_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        advance;
   logic        flush;
   logic        issue_valid;
   logic        issue_we;
   logic        issue_is_load;
   logic [4:0]  issue_rd;
   logic [9:0]  src_addr;
   logic [63:0] rf_data;
   logic [95:0] stage_data;
   logic        stall;
   logic        op_valid;
   logic [63:0] operand;
   logic [3:0]  fwd_sel;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   operand_bypass_unit dut (
      .clk           (clk),
      .rst           (rst),
      .advance       (advance),
      .flush         (flush),
      .issue_valid   (issue_valid),
      .issue_we      (issue_we),
      .issue_is_load (issue_is_load),
      .issue_rd      (issue_rd),
      .src_addr      (src_addr),
      .rf_data       (rf_data),
      .stage_data    (stage_data),
      .stall         (stall),
      .op_valid      (op_valid),
      .operand       (operand),
      .fwd_sel       (fwd_sel)
   );

   typedef struct {
      logic        adv, fl, iv, we, ld;
      logic [4:0]  rd, s0, s1;
      logic [31:0] sd0, sd1, sd2;
      logic        st, ov;
      logic [31:0] o0, o1;
      logic [1:0]  f0, f1;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic vec_t v(input logic adv, fl, iv, we, ld,
                              input logic [4:0] rd, s0, s1,
                              input logic st, ov,
                              input logic [31:0] o0, o1,
                              input logic [1:0] f0, f1);
      vec_t t;
      t.adv = adv; t.fl = fl; t.iv = iv; t.we = we; t.ld = ld;
      t.rd = rd; t.s0 = s0; t.s1 = s1;
      t.sd0 = SA; t.sd1 = SB; t.sd2 = SC;
      t.st = st; t.ov = ov; t.o0 = o0; t.o1 = o1; t.f0 = f0; t.f1 = f1;
      return t;
   endfunction

   task automatic drive(input vec_t t);
      advance       = t.adv;
      flush         = t.fl;
      issue_valid   = t.iv;
      issue_we      = t.we;
      issue_is_load = t.ld;
      issue_rd      = t.rd;
      src_addr      = {t.s1, t.s0};
      stage_data    = {t.sd2, t.sd1, t.sd0};
   endtask

   task automatic check_out(input string tag, input logic ov, input logic [31:0] o0, o1,
                            input logic [1:0] f0, f1);
      check({tag, " op_valid"}, 32'(op_valid), 32'(ov));
      check({tag, " operand0"}, operand[31:0], o0);
      check({tag, " operand1"}, operand[63:32], o1);
      check({tag, " fwd_sel0"}, 32'(fwd_sel[1:0]), 32'(f0));
      check({tag, " fwd_sel1"}, 32'(fwd_sel[3:2]), 32'(f1));
   endtask

   initial begin
      vec_t t;
      string tag;

      rf_data = {RF1, RF0};
      drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset stall", 32'(stall), 32'd0);
      check_out("reset", 1'b0, 32'd0, 32'd0, 2'd0, 2'd0);
      rst = 1'b0;

      //          adv fl iv we ld rd  s0  s1  st ov o0      o1   f0 f1
      vq.push_back(v(1, 0, 1, 1, 0, 3,  1,  2,  0, 1, RF0,    RF1, 0, 0)); // 1 write r3
      vq.push_back(v(1, 0, 1, 1, 0, 0,  3,  0,  0, 1, SA,     RF1, 1, 0)); // 2 back-to-back r3, write r0
      vq.push_back(v(1, 0, 1, 0, 0, 0,  0,  3,  0, 1, RF0,    SB,  0, 2)); // 3 r0 never tracked, r3 in MEM
      vq.push_back(v(1, 0, 1, 1, 0, 7,  3,  3,  0, 1, SC,     SC,  3, 3)); // 4 r3 in WB both ports
      vq.push_back(v(1, 0, 1, 1, 0, 8,  9,  9,  0, 1, RF0,    RF1, 0, 0)); // 5 no match
      vq.push_back(v(1, 0, 1, 1, 0, 7,  7,  7,  0, 1, SB,     SB,  2, 2)); // 6 r7 in MEM
      t = v(1, 0, 1, 0, 0, 0, 7, 7, 0, 1, 32'hA, 32'hA, 1, 1);             // 7 youngest r7 wins
      t.sd0 = 32'hA; t.sd1 = 32'hC; t.sd2 = 32'hB;
      vq.push_back(t);
      vq.push_back(v(1, 0, 1, 1, 1, 5,  1,  2,  0, 1, RF0,    RF1, 0, 0)); // 8 lw r5
      vq.push_back(v(1, 0, 1, 1, 0, 6,  5,  6,  1, 0, RF0,    RF1, 0, 0)); // 9 load in EX: stall
      vq.push_back(v(1, 0, 1, 1, 0, 6,  5,  6,  1, 0, RF0,    RF1, 0, 0)); // 10 load in MEM: stall
      vq.push_back(v(1, 0, 1, 1, 0, 6,  5,  6,  0, 1, SC,     RF1, 3, 0)); // 11 load in WB: forward
      vq.push_back(v(1, 0, 1, 1, 1, 10, 0,  0,  0, 1, RF0,    RF1, 0, 0)); // 12 lw r10
      vq.push_back(v(1, 0, 1, 1, 0, 11, 1,  2,  0, 1, RF0,    RF1, 0, 0)); // 13 independent
      vq.push_back(v(1, 0, 1, 1, 0, 12, 6,  10, 1, 0, RF0,    RF1, 0, 0)); // 14 load in MEM: 1 stall
      vq.push_back(v(1, 0, 1, 1, 0, 12, 6,  10, 0, 1, RF0,    SC,  0, 3)); // 15 released
      vq.push_back(v(1, 0, 1, 1, 1, 13, 1,  2,  0, 1, RF0,    RF1, 0, 0)); // 16 lw r13
      vq.push_back(v(1, 0, 0, 0, 0, 0,  13, 1,  0, 0, SA,     RF1, 1, 0)); // 17 invalid issue never stalls
      vq.push_back(v(0, 0, 1, 0, 0, 0,  12, 0,  0, 0, SA,     RF1, 1, 0)); // 18 frozen
      vq.push_back(v(0, 0, 1, 0, 0, 0,  12, 0,  0, 0, SA,     RF1, 1, 0)); // 19 frozen
      vq.push_back(v(0, 0, 1, 0, 0, 0,  12, 0,  0, 0, SA,     RF1, 1, 0)); // 20 frozen
      vq.push_back(v(1, 0, 1, 0, 0, 0,  12, 0,  0, 1, SC,     RF1, 3, 0)); // 21 resume, r12 still in WB
      vq.push_back(v(1, 0, 1, 1, 1, 20, 1,  2,  0, 1, RF0,    RF1, 0, 0)); // 22 lw r20
      vq.push_back(v(1, 1, 1, 1, 0, 20, 20, 0,  1, 0, 0,      0,   0, 0)); // 23 flush during stall
      vq.push_back(v(1, 0, 1, 0, 0, 0,  20, 0,  0, 1, RF0,    RF1, 0, 0)); // 24 r20 from RF
      vq.push_back(v(1, 1, 1, 1, 0, 22, 1,  2,  0, 0, 0,      0,   0, 0)); // 25 flush beats capture
      vq.push_back(v(1, 0, 1, 0, 0, 0,  22, 22, 0, 1, RF0,    RF1, 0, 0)); // 26 r22 not tracked

      for (int i = 0; i < vq.size(); i++) begin
         tag = $sformatf("vec%0d", i + 1);
         drive(vq[i]);
         #1;
         check({tag, " stall"}, 32'(stall), 32'(vq[i].st));
         @(posedge clk);
         #1;
         check_out(tag, vq[i].ov, vq[i].o0, vq[i].o1, vq[i].f0, vq[i].f1);
      end

      // Reset while a load-use stall is pending.
      drive(v(1, 0, 1, 1, 1, 21, 1, 2, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      drive(v(1, 0, 1, 0, 0, 0, 21, 0, 0, 0, 0, 0, 0, 0));
      #1;
      check("rst_seq stall before", 32'(stall), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_seq stall after", 32'(stall), 32'd0);
      check_out("rst_seq cleared", 1'b0, 32'd0, 32'd0, 2'd0, 2'd0);
      @(posedge clk);
      #1;
      check_out("rst_seq reread", 1'b1, RF0, RF1, 2'd0, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
